// File: rtl/sevenseg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scanner with a one-deep pending buffer
// that swaps into the displayed value only at frame boundaries.
module sevenseg_scan_ctrl #(
    parameter int unsigned ON_CYCLES    = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] in_value,
    input  logic [3:0]  in_dp,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        lz_en,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    localparam int unsigned MaxCycles = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
    localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;
    localparam logic [CntW-1:0] OnLast    = CntW'(ON_CYCLES - 1);
    localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYCLES - 1);

    typedef enum logic [0:0] {StBlank, StDrive} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      idx_q, idx_d;
    logic [15:0]     act_val_q, act_val_d;
    logic [3:0]      act_dp_q, act_dp_d;
    logic [15:0]     pend_val_q, pend_val_d;
    logic [3:0]      pend_dp_q, pend_dp_d;
    logic            pend_full_q, pend_full_d;
    logic [3:0]      an_q, an_d;
    logic [6:0]      seg_q, seg_d;
    logic            dp_q, dp_d;
    logic            frame_done_q, frame_done_d;
    logic [3:0]      nib;

    // Active-high segments, bit 6 = a ... bit 0 = g.
    function automatic logic [6:0] decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0:    s = 7'b111_1110;
            4'd1:    s = 7'b011_0000;
            4'd2:    s = 7'b110_1101;
            4'd3:    s = 7'b111_1001;
            4'd4:    s = 7'b011_0011;
            4'd5:    s = 7'b101_1011;
            4'd6:    s = 7'b101_1111;
            4'd7:    s = 7'b111_0000;
            4'd8:    s = 7'b111_1111;
            4'd9:    s = 7'b111_0011;
            default: s = 7'b000_0000;
        endcase
        return s;
    endfunction

    // A digit is a leading zero when it and every digit to its left are zero.
    function automatic logic is_leading_zero(input logic [15:0] v, input logic [1:0] i);
        logic z;
        case (i)
            2'd0:    z = 1'b0;
            2'd1:    z = (v[15:4] == 12'h000);
            2'd2:    z = (v[15:8] == 8'h00);
            default: z = (v[15:12] == 4'h0);
        endcase
        return z;
    endfunction

    assign in_ready   = ~pend_full_q & ~reset;
    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_done = frame_done_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 1'b1;
        idx_d       = idx_q;
        act_val_d   = act_val_q;
        act_dp_d    = act_dp_q;
        pend_val_d  = pend_val_q;
        pend_dp_d   = pend_dp_q;
        pend_full_d = pend_full_q;

        unique case (state_q)
            StBlank: begin
                if (cnt_q == BlankLast) begin
                    state_d = StDrive;
                    cnt_d   = '0;
                end
            end
            StDrive: begin
                if (cnt_q == OnLast) begin
                    state_d = StBlank;
                    cnt_d   = '0;
                    idx_d   = idx_q + 2'd1;
                end
            end
        endcase

        // in_ready is low whenever pending is full, so these never collide.
        if (frame_done_q && pend_full_q) begin
            act_val_d   = pend_val_q;
            act_dp_d    = pend_dp_q;
            pend_full_d = 1'b0;
        end
        if (in_valid && in_ready) begin
            pend_val_d  = in_value;
            pend_dp_d   = in_dp;
            pend_full_d = 1'b1;
        end
    end

    // Outputs are computed from next state so the registered pins line up with state_q.
    always_comb begin
        an_d  = 4'hF;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        nib   = act_val_d[{idx_d, 2'b00} +: 4];
        if (state_d == StDrive) begin
            an_d  = ~(4'b0001 << idx_d);
            seg_d = (lz_en && is_leading_zero(act_val_d, idx_d)) ? 7'h7F : ~decode(nib);
            dp_d  = ~act_dp_d[idx_d];
        end
        frame_done_d = (state_d == StDrive) && (idx_d == 2'd3) && (cnt_d == OnLast);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StBlank;
            cnt_q        <= '0;
            idx_q        <= 2'd0;
            act_val_q    <= 16'h0000;
            act_dp_q     <= 4'b0000;
            pend_val_q   <= 16'h0000;
            pend_dp_q    <= 4'b0000;
            pend_full_q  <= 1'b0;
            an_q         <= 4'hF;
            seg_q        <= 7'h7F;
            dp_q         <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            act_val_q    <= act_val_d;
            act_dp_q     <= act_dp_d;
            pend_val_q   <= pend_val_d;
            pend_dp_q    <= pend_dp_d;
            pend_full_q  <= pend_full_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_done_q <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Scoreboard bench for sevenseg_scan_ctrl with ON_CYCLES=4, BLANK_CYCLES=1 (20-cycle frame).
module tb_sevenseg_scan_ctrl;

    localparam int Slot  = 5;
    localparam int Frame = 20;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] in_value = 16'h0;
    logic [3:0]  in_dp = 4'h0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        lz_en = 1'b0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    int checks = 0;
    int failures = 0;
    int cyc = 1;
    int pos;
    bit armed = 1'b0;
    logic [11:0] exp_q[$];
    logic [3:0]  prev_an = 4'hF;

    sevenseg_scan_ctrl #(
        .ON_CYCLES   (4),
        .BLANK_CYCLES(1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_value  (in_value),
        .in_dp     (in_dp),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .lz_en     (lz_en),
        .an        (an),
        .seg       (seg),
        .dp        (dp),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Cycle number within the run; 1 is the first cycle after the last reset edge.
    always @(posedge clk) cyc <= reset ? 1 : cyc + 1;
    always_comb pos = (cyc - 1) % Frame + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    // Active-low segment patterns, g in bit 0.
    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'd0: return 7'h01;
            4'd1: return 7'h4F;
            4'd2: return 7'h12;
            4'd3: return 7'h06;
            4'd4: return 7'h4C;
            4'd5: return 7'h24;
            4'd6: return 7'h20;
            4'd7: return 7'h0F;
            4'd8: return 7'h00;
            4'd9: return 7'h0C;
            default: return 7'h7F;
        endcase
    endfunction

    task automatic push_frame(input logic [15:0] v, input logic [3:0] pdp, input bit lz,
                              input int n);
        for (int i = 0; i < n; i++) begin
            logic [6:0] s;
            logic [3:0] a;
            s = seg_of(v[4*i +: 4]);
            if (lz && i > 0 && (v >> (4 * i)) == 16'h0) s = 7'h7F;
            a = ~(4'b0001 << i);
            exp_q.push_back({a, s, ~pdp[i]});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic goto_pos(input int p);
        int n = 0;
        while (pos != p && n < 45) begin
            tick();
            n++;
        end
        if (pos != p) begin
            checks++;
            failures++;
            $display("FAIL goto_pos got=%0d exp=%0d", pos, p);
        end
    endtask

    task automatic next_frame();
        tick();
        goto_pos(1);
    endtask

    task automatic offer(input logic [15:0] v, input logic [3:0] d);
        in_value = v;
        in_dp    = d;
        in_valid = 1'b1;
        #1 check("ready_offer", in_ready, 1);
        tick();
        in_valid = 1'b0;
        in_value = 16'h8888;
        in_dp    = 4'hF;
        #1 check("ready_after_accept", in_ready, 0);
    endtask

    // Monitor: per-cycle slot timing plus one scoreboard pop per digit presentation.
    always @(negedge clk) begin
        int q;
        int d;
        logic [3:0] ea;
        logic [11:0] e;
        if (armed) begin
            q  = (pos - 1) % Slot;
            d  = (pos - 1) / Slot;
            ea = (q == 0) ? 4'hF : ~(4'b0001 << d);
            check("an_slot", an, ea);
            check("frame_done", frame_done, pos == Frame);
            if (an == 4'hF) check("blank_seg_dp", {seg, dp}, 8'hFF);
            if (an != 4'hF && prev_an == 4'hF) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_underflow got=%0h exp=none", {an, seg, dp});
                end else begin
                    e = exp_q.pop_front();
                    check("digit", {an, seg, dp}, e);
                end
            end
            prev_an = an;
        end
    end

    initial begin
        @(posedge clk);
        #1 armed = 1'b1;
        tick();
        tick();
        check("ready_in_reset", in_ready, 0);
        check("reset_outputs", {an, seg, dp, frame_done}, {4'hF, 7'h7F, 1'b1, 1'b0});
        reset = 1'b0;
        #1 check("ready_idle", in_ready, 1);

        // F1: idle zeros; 1234 offered mid-frame
        push_frame(16'h0000, 4'b0000, 1'b0, 4);
        goto_pos(8);
        offer(16'h1234, 4'b0100);
        goto_pos(20);
        check("ready_until_fd", in_ready, 0);
        next_frame();
        check("ready_after_fd", in_ready, 1);

        // F2: 1234 with dp on digit 2
        push_frame(16'h1234, 4'b0100, 1'b0, 4);
        goto_pos(5);
        offer(16'h0007, 4'b0000);
        next_frame();

        // F3: 0007 suppressed, F4: 0007 unsuppressed (active kept, nothing pending)
        lz_en = 1'b1;
        push_frame(16'h0007, 4'b0000, 1'b1, 4);
        next_frame();
        lz_en = 1'b0;
        push_frame(16'h0007, 4'b0000, 1'b0, 4);

        // Back-to-back 1111 then 2222 with in_valid held
        goto_pos(3);
        in_value = 16'h1111;
        in_dp    = 4'b0000;
        in_valid = 1'b1;
        tick();
        in_value = 16'h2222;
        #1 check("ready_hold", in_ready, 0);
        goto_pos(20);
        check("ready_hold_fd", in_ready, 0);
        next_frame();
        check("ready_second", in_ready, 1);
        push_frame(16'h1111, 4'b0000, 1'b0, 4);
        tick();
        in_valid = 1'b0;
        #1 check("ready_second_taken", in_ready, 0);
        next_frame();
        push_frame(16'h2222, 4'b0000, 1'b0, 4);
        goto_pos(10);
        offer(16'h0C05, 4'b0001);
        next_frame();

        // F7: invalid nibble C plus leading-zero on digit 3 only
        lz_en = 1'b1;
        push_frame(16'h0C05, 4'b0001, 1'b1, 4);
        next_frame();

        // F8: pending 9999, then reset mid-DRIVE of digit 2
        push_frame(16'h0C05, 4'b0001, 1'b1, 3);
        goto_pos(3);
        offer(16'h9999, 4'hF);
        goto_pos(13);
        reset = 1'b1;
        tick();
        check("rst_off", {an, seg, dp, frame_done}, {4'hF, 7'h7F, 1'b1, 1'b0});
        check("ready_rst_mid", in_ready, 0);
        tick();
        reset = 1'b0;
        lz_en = 1'b0;
        #1 check("ready_after_reset", in_ready, 1);
        push_frame(16'h0000, 4'b0000, 1'b0, 4);
        next_frame();
        push_frame(16'h0000, 4'b0000, 1'b0, 4);
        next_frame();
        check("sb_drain", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
